// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over req/ack, and hands them
// to decode over valid/ready; next PC is resolved from branch/jump on retire.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        stall,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: imem beat completes in any FETCH cycle with imem_ack=1 (rdata
    // sampled the same cycle); decode beat completes when instr_valid & instr_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_next_pc;
    logic          w_retire;
    logic          w_ack;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_retire   = (r_state == S_VALID) && instr_ready;
    assign w_ack      = (r_state == S_FETCH) && imem_ack;

    // Jump wins over branch; there is no delay slot.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            w_next_pc = w_pc_plus4 + {branch_offset[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ack) begin
                r_instr    <= imem_rdata;
                r_wait_cnt <= '0;
            end else if (r_state == S_FETCH) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (!stall) w_next_state = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    w_next_state = S_VALID;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_next_state = S_ERROR;
                end
            end
            S_VALID: if (instr_ready) w_next_state = stall ? S_IDLE : S_FETCH;
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == S_FETCH);
        instr_valid = (r_state == S_VALID);
        fetch_err   = (r_state == S_ERROR);
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_instr;
    assign opcode    = r_instr[31:26];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential flow, branch/jump redirect, stall and
// backpressure, fetch timeout, PC wrap and asynchronous reset mid-fetch.
module tb_instr_fetch;

  logic        clk;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        stall;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (4)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .fetch_err     (fetch_err),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // invariants sampled on the falling edge
  always @(negedge clk) begin
    if (nrst) begin
      check("req_valid_excl", {31'd0, imem_req & instr_valid}, 32'd0);
      check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_redirect();
    branch_taken  = 1'b1;
    jump          = 1'b1;
    branch_offset = 32'h0000_0100;
    jump_target   = 26'h3FF_FFFF;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_err"},   {31'd0, fetch_err}, 32'd0);
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_pc4"},   pc_plus4, 32'h4);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_op"},    {26'd0, opcode}, 32'd0);
  endtask

  // expects to be in FETCH at exp_addr; acks this cycle, then checks VALID view
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("valid", {31'd0, instr_valid}, 32'd1);
    check("valid_noreq", {31'd0, imem_req}, 32'd0);
    check("instr", instr, word);
    check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("pc", pc, exp_addr);
    check("pc_plus4", pc_plus4, exp_addr + 32'd4);
  endtask

  task automatic do_retire(input logic jmp, input logic [25:0] tgt, input logic br,
                           input logic [31:0] off, input logic stl);
    instr_ready   = 1'b1;
    jump          = jmp;
    jump_target   = tgt;
    branch_taken  = br;
    branch_offset = off;
    stall         = stl;
    step();
    instr_ready = 1'b0;
    check("retire_novalid", {31'd0, instr_valid}, 32'd0);
    junk_redirect();
  endtask

  initial begin
    nrst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_target = 26'h0;
    stall = 1'b0;

    // 1. reset, then sequential fetch
    step(); step();
    check_reset("rst");
    nrst = 1'b1;
    step();
    do_fetch(32'h0, 32'h2008_0005);
    check("op_addi", {26'd0, opcode}, 32'h08);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h4, 32'h0000_0000);
    check("pc4_second", pc_plus4, 32'h8);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h8, 32'h1111_1111);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'hC, 32'h2222_2222);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);

    // 2. branch backwards from 0x10, then not-taken
    do_fetch(32'h10, 32'h1000_FFFE);
    do_retire(1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    do_fetch(32'hC, 32'h3333_3333);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h10, 32'h1000_FFFE);
    do_retire(1'b0, 26'h0, 1'b0, 32'hFFFF_FFFE, 1'b0);
    do_fetch(32'h14, 32'h4444_4444);
    // 0x18 + 0x0400000A*4 = 0x1000_0040
    do_retire(1'b0, 26'h0, 1'b1, 32'h0400_000A, 1'b0);

    // 3. jump beats branch on the same retire
    do_fetch(32'h1000_0040, 32'h0800_0100);
    do_retire(1'b1, 26'h000_0100, 1'b1, 32'h0000_0010, 1'b0);

    // 4. backpressure then retire into stall
    do_fetch(32'h1000_0400, 32'h8C41_0004);
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      step();
      check("bp_instr", instr, 32'h8C41_0004);
      check("bp_pc", pc, 32'h1000_0400);
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_noreq", {31'd0, imem_req}, 32'd0);
    end
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
      check("stall_pc", pc, 32'h1000_0404);
    end
    stall = 1'b0;
    step();
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    stall = 1'b1;
    do_fetch(32'h1000_0404, 32'h5555_5555);
    // 0x1000_0408 + 0x3BFFFEFD*4 = 0xFFFF_FFFC
    do_retire(1'b0, 26'h0, 1'b1, 32'h3BFF_FEFD, 1'b0);

    // wrap-around
    do_fetch(32'hFFFF_FFFC, 32'h6666_6666);
    check("wrap_pc4", pc_plus4, 32'h0);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);

    // 5. ack on the last allowed cycle, then a true timeout
    for (int i = 0; i < 3; i++) begin
      check("slow_req", {31'd0, imem_req}, 32'd1);
      step();
    end
    do_fetch(32'h0, 32'h7777_7777);
    check("slow_noerr", {31'd0, fetch_err}, 32'd0);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("to_req", {31'd0, imem_req}, 32'd1);
      check("to_noerr", {31'd0, fetch_err}, 32'd0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      imem_ack = i[0];
      instr_ready = 1'b1;
      check("err_flag", {31'd0, fetch_err}, 32'd1);
      check("err_noreq", {31'd0, imem_req}, 32'd0);
      check("err_novalid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;

    // 6. async reset mid-fetch at 0x20 with an ack pending
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    step();
    do_fetch(32'h0, 32'h0800_0008);
    do_retire(1'b1, 26'h000_0008, 1'b0, 32'h0, 1'b0);
    check("pre_rst_addr", imem_addr, 32'h20);
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCD_1234;
    #2;
    nrst = 1'b0;
    #1;
    check_reset("async");
    step();
    nrst = 1'b1;
    step();
    imem_ack = 1'b0;
    check("stale_ignored", {31'd0, instr_valid}, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_instr", instr, 32'h0);
    step();
    check("restart_still_req", {31'd0, imem_req}, 32'd1);
    do_fetch(32'h0, 32'h2008_0005);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
    step();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit that produces the instruction word and 6-bit opcode consumed by the opcode decoder. It owns the PC, fetches words from instruction memory over a req/ack handshake, and presents each instruction to decode over a valid/ready handshake. It computes the next PC from branch/jump resolution returned by the datapath when the current instruction retires.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
MAX_WAIT, 16, cycles FETCH may wait for imem_ack before a fetch error (range 2..255).

Ports:
clk  in  1  clock; all state updates on rising edge.
nrst  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request, high for the whole FETCH state.
imem_addr  out  32  word address being fetched; equals pc; stable while imem_req=1.
imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
instr  out  32  held instruction word.
opcode  out  6  instr[31:26], feeds the decoder opcode input.
instr_valid  out  1  instr/opcode valid for decode.
instr_ready  in  1  decode/datapath retires the instruction this cycle.
pc  out  32  address of the held/in-flight instruction.
pc_plus4  out  32  pc + 4, used as the JAL link value.
branch_taken  in  1  branch condition met (branch AND compare result); sampled only on retire.
branch_offset  in  32  sign-extended 16-bit immediate; sampled only on retire.
jump  in  1  J/JAL selected (decoder branch/jump mux = jump); sampled only on retire.
jump_target  in  26  instr[25:0]; sampled only on retire.
stall  in  1  inhibits starting a new fetch; never aborts an in-flight fetch.
fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0. opcode=0. pc_plus4=RESET_PC+4.
- States: IDLE, FETCH, VALID, ERROR. All outputs are driven from registers or from the current state only; there are no combinational paths from inputs to outputs.
- IDLE: if stall=0, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH: imem_req=1, imem_addr=pc. The wait counter increments each cycle without imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, counter<=0, go to VALID. instr_valid is high in the cycle after the ack.
  - If the counter reaches MAX_WAIT-1 without an ack, the next cycle enters ERROR: fetch_err<=1, imem_req<=0.
  - An ack arriving in the same cycle the limit is reached takes priority over the timeout.
- VALID: instr, opcode and pc are held stable until instr_ready=1. On retire (instr_valid & instr_ready):
  - instr_valid<=0 and pc<=next_pc.
  - Go to FETCH if stall=0, else go to IDLE.
- next_pc priority: jump first, then branch_taken, then sequential.
  - jump=1: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch_taken=1: pc_plus4 + (branch_offset<<2), mod 2^32.
  - Otherwise: pc_plus4.
  - There is no delay slot.
- Arithmetic: all PC arithmetic is 32-bit with wrap-around; pc=32'hFFFF_FFFC sequentially becomes 0.
- Redirect inputs are ignored in every cycle except a retire cycle.
- ERROR: terminal state. imem_req=0, instr_valid=0, fetch_err=1. Only nrst exits ERROR.
- Throughput: at most one instruction per two cycles (ack-cycle → VALID → retire → next FETCH).
- Back-to-back: retire with stall=0 gives imem_req=1 in the very next cycle at the new pc.
- A stall change during FETCH or VALID has no effect until the next fetch start decision.
- Reset mid-fetch: outputs return to reset values immediately (asynchronously). A late imem_ack after reset release is ignored, because state is IDLE.
- Invariants: the assertion bench checks that imem_req and instr_valid are never both 1, and that imem_addr[1:0]=2'b00 always.

Test Plan:
1. Reset then sequential fetch: nrst released, stall=0, memory acks 1 cycle after each req with words 0x20080005, 0x00000000; instr_ready=1 → imem_addr 0x0, then 0x4; opcode 6'h08, then 6'h00; pc_plus4 0x4, then 0x8.
2. Branch: hold pc=0x10, branch_taken=1, branch_offset=32'hFFFF_FFFE on retire → next imem_addr=0x0C. With branch_taken=0 on retire → 0x14.
3. Jump priority: pc=0x1000_0040, jump=1, jump_target=26'h0000100, branch_taken=1 on the same retire → imem_addr=0x1000_0400.
4. Backpressure/stall: instr_ready=0 for 5 cycles → instr, opcode and pc stable, no imem_req. Then retire with stall=1 → IDLE, no req until stall=0, req on the cycle after stall falls.
5. Timeout: MAX_WAIT=4, never ack → imem_req high 4 cycles, then fetch_err=1 and req=0 forever. An ack on cycle 4 instead → normal VALID with fetch_err=0.
6. Async reset mid-fetch at pc=0x20 with a pending ack → all outputs at reset values in the same cycle; after release, the fetch restarts at RESET_PC and the stale ack is ignored.
